dm_ctrl: RTL and testbench

Data-memory access controller for the MEM stage: the initiator side of the word-wide data memory port (10-bit word address, 32-bit write data, write enable, combinational 32-bit read data, write on rising clock edge). Accepts one load/store request at a time from the pipeline. Performs sign/zero extension for sub-word loads and read-modify-write for byte/halfword stores. Reports completion and misalignment back to the pipeline, which stalls while `busy` is high.

---
 rtl/dm_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_dm_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_ctrl.sv
// dm_ctrl: MEM-stage data-memory access controller.
// Serves one load/store at a time against a word-wide memory with
// combinational read data. Sub-word loads are extended here, and sub-word
// stores use a read-modify-write sequence.
module dm_ctrl #(
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic [2:0]    op,
  input  logic [31:0]   addr,
  input  logic [31:0]   wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [31:0]   rdata,
  output logic [AW-1:0] dm_addr,
  output logic [31:0]   dm_din,
  output logic          dm_we,
  input  logic [31:0]   dm_dout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_LH  = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SB  = 3'b110;
  localparam logic [2:0] OP_SH  = 3'b111;

  state_t        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          err_q, err_d;
  logic [31:0]   buf_q, buf_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          misaligned;
  logic          is_load;
  logic [31:0]   load_ext;
  logic [31:0]   merged;
  logic [7:0]    sel_byte;
  logic [15:0]   sel_half;

  // Upper address bits lie outside the memory and are deliberately ignored.
  logic unused_addr;
  assign unused_addr = ^addr[31:AW+2];

  // Alignment check on the incoming request.
  always_comb begin
    misaligned = 1'b0;
    case (op)
      OP_LW, OP_SW:         misaligned = (addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: misaligned = addr[0];
      default:              misaligned = 1'b0;
    endcase
  end

  // Load extraction and sign/zero extension from the addressed memory word.
  always_comb begin
    is_load  = (op_q == OP_LW) || (op_q == OP_LB) || (op_q == OP_LBU) ||
               (op_q == OP_LH) || (op_q == OP_LHU);
    sel_byte = dm_dout[7:0];
    case (addr_q[1:0])
      2'd0:    sel_byte = dm_dout[7:0];
      2'd1:    sel_byte = dm_dout[15:8];
      2'd2:    sel_byte = dm_dout[23:16];
      default: sel_byte = dm_dout[31:24];
    endcase
    sel_half = addr_q[1] ? dm_dout[31:16] : dm_dout[15:0];
    case (op_q)
      OP_LB:   load_ext = {{24{sel_byte[7]}}, sel_byte};
      OP_LBU:  load_ext = {24'd0, sel_byte};
      OP_LH:   load_ext = {{16{sel_half[15]}}, sel_half};
      OP_LHU:  load_ext = {16'd0, sel_half};
      default: load_ext = dm_dout;
    endcase
  end

  // Merge the store byte/halfword into the previously read word.
  always_comb begin
    merged = buf_q;
    if (op_q == OP_SB) begin
      case (addr_q[1:0])
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (op_q == OP_SH) begin
      if (addr_q[1]) merged[31:16] = wdata_q[15:0];
      else           merged[15:0]  = wdata_q[15:0];
    end
  end

  // Next-state and request-field update logic.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    buf_d   = buf_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          op_d    = op;
          addr_d  = addr[AW+1:0];
          wdata_d = wdata;
          err_d   = misaligned;
          state_d = misaligned ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        if (is_load) begin
          rdata_d = load_ext;
          state_d = DONE;
        end else if (op_q == OP_SW) begin
          state_d = DONE;
        end else begin
          buf_d   = dm_dout;
          state_d = WRITE;
        end
      end
      WRITE:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // State and request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      buf_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      buf_q   <= buf_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs decoded from registered state and registered request fields only.
  always_comb begin
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    err     = (state_q == DONE) && err_q;
    rdata   = rdata_q;
    dm_addr = addr_q[AW+1:2];
    dm_we   = 1'b0;
    dm_din  = '0;
    if (state_q == ACCESS && op_q == OP_SW) begin
      dm_we  = 1'b1;
      dm_din = wdata_q;
    end else if (state_q == WRITE) begin
      dm_we  = 1'b1;
      dm_din = merged;
    end
  end

endmodule

// File: tb/tb_dm_ctrl.sv
// Testbench for dm_ctrl: directed load/store scenarios against a simple
// word memory model with combinational read and clocked write.
module tb_dm_ctrl;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_LH  = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SB  = 3'b110;
  localparam logic [2:0] OP_SH  = 3'b111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        busy, done, err, dm_we;
  logic [31:0] rdata, dm_din, dm_dout;
  logic [9:0]  dm_addr;

  logic [31:0] mem [0:1023];
  logic        pl_we = 1'b0;
  logic [9:0]  pl_a = 10'd0;
  logic [31:0] pl_d = 32'd0;

  int checks = 0;
  int failures = 0;

  dm_ctrl #(.AW(10)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata),
    .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we), .dm_dout(dm_dout)
  );

  always #5 clk = ~clk;

  assign dm_dout = mem[dm_addr];

  always @(posedge clk) begin
    if (pl_we) mem[pl_a] <= pl_d;
    else if (dm_we) mem[dm_addr] <= dm_din;
  end

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_a = a; pl_d = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  // Issue one request and observe it until done (bounded).
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w,
                       output int lat, output logic e, output int wecnt,
                       output logic [9:0] wa);
    @(negedge clk);
    op = o; addr = a; wdata = w; req = 1'b1;
    @(posedge clk);
    lat = 1; wecnt = 0; wa = '0; e = 1'b0;
    @(negedge clk);
    req = 1'b0;
    while (!done && lat < 10) begin
      if (dm_we) begin wecnt++; wa = dm_addr; end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (done) begin
      e = err;
      if (dm_we) wecnt++;
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({busy, done, err, dm_we} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctl got=%b exp=0000", {busy, done, err, dm_we});
    end
    checks++;
    if ({dm_addr, dm_din, rdata} !== 74'd0) begin
      failures++;
      $display("FAIL reset_data got addr=%h din=%h rdata=%h exp=0", dm_addr, dm_din, rdata);
    end
    preload(10'd4, 32'h8899AABB);
    preload(10'd8, 32'h00000000);
    preload(10'd9, 32'h11223344);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_loads;
    logic [2:0]  ops  [6] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LB, OP_LBU};
    logic [31:0] adrs [6] = '{32'h11, 32'h11, 32'h12, 32'h10, 32'h13, 32'h10};
    logic [31:0] exps [6] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899,
                              32'h0000AABB, 32'hFFFFFF88, 32'h000000BB};
    int lat, wc;
    logic e;
    logic [9:0] wa;
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], adrs[i], 32'hFFFFFFFF, lat, e, wc, wa);
      checks++;
      if (rdata !== exps[i]) begin
        failures++;
        $display("FAIL load%0d_rdata got=%h exp=%h", i, rdata, exps[i]);
      end
      checks++;
      if (lat !== 2 || e !== 1'b0 || wc !== 0) begin
        failures++;
        $display("FAIL load%0d_timing got lat=%0d err=%b we=%0d exp lat=2 err=0 we=0", i, lat, e, wc);
      end
    end
  endtask

  task automatic test_word;
    int lat, wc;
    logic e;
    logic [9:0] wa;
    issue(OP_SW, 32'h20, 32'hDEADBEEF, lat, e, wc, wa);
    checks++;
    if (lat !== 2 || e !== 1'b0 || wc !== 1 || wa !== 10'd8) begin
      failures++;
      $display("FAIL sw_seq got lat=%0d err=%b we=%0d addr=%0d exp 2 0 1 8", lat, e, wc, wa);
    end
    checks++;
    if (mem[8] !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL sw_mem got=%h exp=deadbeef", mem[8]);
    end
    issue(OP_LW, 32'h20, 32'h0, lat, e, wc, wa);
    checks++;
    if (rdata !== 32'hDEADBEEF || lat !== 2) begin
      failures++;
      $display("FAIL lw got rdata=%h lat=%0d exp deadbeef 2", rdata, lat);
    end
  endtask

  task automatic test_subword_store;
    int lat, wc;
    logic e;
    logic [9:0] wa;
    issue(OP_SB, 32'h22, 32'hFFFFFF55, lat, e, wc, wa);
    checks++;
    if (lat !== 3 || e !== 1'b0 || wc !== 1 || wa !== 10'd8) begin
      failures++;
      $display("FAIL sb_seq got lat=%0d err=%b we=%0d addr=%0d exp 3 0 1 8", lat, e, wc, wa);
    end
    checks++;
    if (mem[8] !== 32'hDE55BEEF) begin
      failures++;
      $display("FAIL sb_mem got=%h exp=de55beef", mem[8]);
    end
    issue(OP_SH, 32'h20, 32'hFFFF1234, lat, e, wc, wa);
    checks++;
    if (lat !== 3 || e !== 1'b0 || wc !== 1 || wa !== 10'd8) begin
      failures++;
      $display("FAIL sh_seq got lat=%0d err=%b we=%0d addr=%0d exp 3 0 1 8", lat, e, wc, wa);
    end
    checks++;
    if (mem[8] !== 32'hDE551234) begin
      failures++;
      $display("FAIL sh_mem got=%h exp=de551234", mem[8]);
    end
    checks++;
    if (rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL store_keeps_rdata got=%h exp=deadbeef", rdata);
    end
  endtask

  task automatic test_misaligned;
    int lat, wc;
    logic e;
    logic [9:0] wa;
    issue(OP_LW, 32'h21, 32'h0, lat, e, wc, wa);
    checks++;
    if (lat !== 1 || e !== 1'b1 || wc !== 0 || rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL mis_lw got lat=%0d err=%b we=%0d rdata=%h exp 1 1 0 deadbeef", lat, e, wc, rdata);
    end
    issue(OP_SH, 32'h23, 32'h0000ABCD, lat, e, wc, wa);
    checks++;
    if (lat !== 1 || e !== 1'b1 || wc !== 0 || mem[8] !== 32'hDE551234) begin
      failures++;
      $display("FAIL mis_sh got lat=%0d err=%b we=%0d mem=%h exp 1 1 0 de551234", lat, e, wc, mem[8]);
    end
    issue(OP_LW, 32'h20, 32'h0, lat, e, wc, wa);
    checks++;
    if (lat !== 2 || e !== 1'b0 || rdata !== 32'hDE551234) begin
      failures++;
      $display("FAIL err_clear got lat=%0d err=%b rdata=%h exp 2 0 de551234", lat, e, rdata);
    end
  endtask

  task automatic test_back_to_back;
    int wc = 0;
    int dc = 0;
    logic [9:0] wa = '0;
    @(negedge clk);
    op = OP_SW; addr = 32'h30; wdata = 32'hA5A5A5A5; req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (dm_we) begin wc++; if (wc == 1) wa = dm_addr; end
      if (done) dc++;
      if (i == 0) begin addr = 32'h34; wdata = 32'h5A5A5A5A; end
      if (i == 4) req = 1'b0;
    end
    checks++;
    if (wc !== 2 || dc !== 2 || wa !== 10'd12) begin
      failures++;
      $display("FAIL hold_req got we=%0d done=%0d addr=%0d exp 2 2 12", wc, dc, wa);
    end
    checks++;
    if (mem[12] !== 32'hA5A5A5A5 || mem[13] !== 32'h5A5A5A5A) begin
      failures++;
      $display("FAIL hold_mem got %h %h exp a5a5a5a5 5a5a5a5a", mem[12], mem[13]);
    end
  endtask

  task automatic test_reset_in_write;
    int lat, wc;
    logic e;
    logic [9:0] wa;
    @(negedge clk);
    op = OP_SB; addr = 32'h24; wdata = 32'h000000AB; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (dm_we !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL write_state got we=%b busy=%b exp 1 1", dm_we, busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({dm_we, busy, done} !== 3'b000) begin
      failures++;
      $display("FAIL rst_write got we,busy,done=%b exp=000", {dm_we, busy, done});
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (mem[9] !== 32'h11223344) begin
      failures++;
      $display("FAIL rst_mem got=%h exp=11223344", mem[9]);
    end
    issue(OP_LW, 32'h24, 32'h0, lat, e, wc, wa);
    checks++;
    if (lat !== 2 || e !== 1'b0 || rdata !== 32'h11223344) begin
      failures++;
      $display("FAIL post_rst_lw got lat=%0d err=%b rdata=%h exp 2 0 11223344", lat, e, rdata);
    end
  endtask

  initial begin
    test_reset;
    test_loads;
    test_word;
    test_subword_store;
    test_misaligned;
    test_back_to_back;
    test_reset_in_write;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
